// File: rtl/move_issue_pkg.sv
// Shared types for the move-program issue sequencer: opcodes, instruction
// word layout (default widths) and the sequencer FSM states.
package move_issue_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_COND_W = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_MOVE = 2'b01,
    OP_LOOP = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  // MSB to LSB, as stored in instruction memory.
  typedef struct packed {
    opcode_e               opcode;
    logic [DEF_COND_W-1:0] cond_sel;
    logic                  p1;
    logic                  p2;
    logic [DEF_ADDR_W-1:0] addr1;
    logic [DEF_ADDR_W-1:0] addr2;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_FINISH
  } state_e;

endpackage

// File: rtl/move_instr_decode.sv
// Combinational split of a packed move-program word into opcode and move
// argument fields; widths follow the sequencer parameters.
module move_instr_decode
  import move_issue_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int COND_W = 3
) (
  input  logic [2+COND_W+2+2*ADDR_W-1:0] instr,
  output opcode_e                        opcode,
  output logic [COND_W-1:0]              cond_sel,
  output logic                           p1,
  output logic                           p2,
  output logic [ADDR_W-1:0]              addr1,
  output logic [ADDR_W-1:0]              addr2
);

  localparam int INSTR_W = 2 + COND_W + 2 + 2*ADDR_W;

  assign opcode   = opcode_e'(instr[INSTR_W-1 -: 2]);
  assign cond_sel = instr[2*ADDR_W+2 +: COND_W];
  assign p1       = instr[2*ADDR_W+1];
  assign p2       = instr[2*ADDR_W];
  assign addr1    = instr[ADDR_W +: ADDR_W];
  assign addr2    = instr[0 +: ADDR_W];

endmodule

// File: rtl/move_issue_seq.sv
// Fetches move-program words, decodes them and issues moves to the execute
// stage over valid/ready. Define MOVE_ISSUE_STATS_EN to add issued_count.
module move_issue_seq
  import move_issue_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int COND_W = 3,
  parameter int PC_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [PC_W-1:0]                base_pc,
  input  logic [15:0]                    iterations,
  output logic                           imem_en,
  output logic [PC_W-1:0]                imem_addr,
  input  logic [2+COND_W+2+2*ADDR_W-1:0] imem_rdata,
  output logic                           op_valid,
  input  logic                           op_ready,
  output logic [ADDR_W-1:0]              op_data1,
  output logic [ADDR_W-1:0]              op_data2,
  output logic                           op_data1_pointer,
  output logic                           op_data2_pointer,
  output logic [COND_W-1:0]              op_cond_sel,
  output logic                           busy,
  output logic                           done,
  output logic                           error
`ifdef MOVE_ISSUE_STATS_EN
  ,
  output logic [15:0]                    issued_count
`endif
);

  state_e            state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   loop_pc;
  logic [15:0]       iter;

  opcode_e           dec_op;
  logic [COND_W-1:0] dec_cond;
  logic              dec_p1, dec_p2;
  logic [ADDR_W-1:0] dec_a1, dec_a2;

  logic start_acc, decoding, loop_back, advance, pc_last, handshake;

  move_instr_decode #(.ADDR_W(ADDR_W), .COND_W(COND_W)) u_decode (
    .instr    (imem_rdata),
    .opcode   (dec_op),
    .cond_sel (dec_cond),
    .p1       (dec_p1),
    .p2       (dec_p2),
    .addr1    (dec_a1),
    .addr2    (dec_a2)
  );

  assign start_acc = (state == S_IDLE) && start;
  assign decoding  = (state == S_DECODE);
  assign handshake = (state == S_ISSUE) && op_ready;
  assign pc_last   = &pc;
  assign loop_back = decoding && (dec_op == OP_LOOP) && (iter > 16'd1);
  // Every path that steps the PC forward; a step from all-ones is an overflow.
  assign advance   = handshake ||
                     (decoding && (dec_op == OP_NOP)) ||
                     (decoding && (dec_op == OP_LOOP) && !(iter > 16'd1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this process free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_op == OP_MOVE)      state_nxt = S_ISSUE;
        else if (dec_op == OP_HALT) state_nxt = S_FINISH;
        else if (advance && pc_last) state_nxt = S_FINISH;
        else                        state_nxt = S_FETCH;
      end
      S_ISSUE:  if (op_ready) state_nxt = pc_last ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_en   = (state == S_FETCH);
    imem_addr = pc;
    op_valid  = (state == S_ISSUE);
    busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);
    done      = (state == S_FINISH);
  end

  // Loop target is captured at start so a changing base_pc cannot redirect a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= '0;
      loop_pc          <= '0;
      iter             <= '0;
      error            <= 1'b0;
      op_data1         <= '0;
      op_data2         <= '0;
      op_data1_pointer <= 1'b0;
      op_data2_pointer <= 1'b0;
      op_cond_sel      <= '0;
    end else begin
      if (start_acc) begin
        pc      <= base_pc;
        loop_pc <= base_pc;
        iter    <= (iterations == 16'd0) ? 16'd1 : iterations;
        error   <= 1'b0;
      end else if (loop_back) begin
        iter <= iter - 16'd1;
        pc   <= loop_pc;
      end else if (advance) begin
        if (pc_last) error <= 1'b1;
        else         pc    <= pc + PC_W'(1);
      end

      if (decoding && (dec_op == OP_MOVE)) begin
        op_data1         <= dec_a1;
        op_data2         <= dec_a2;
        op_data1_pointer <= dec_p1;
        op_data2_pointer <= dec_p2;
        op_cond_sel      <= dec_cond;
      end
    end
  end

`ifdef MOVE_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               issued_count <= '0;
    else if (start_acc)                      issued_count <= '0;
    else if (handshake && !(&issued_count))  issued_count <= issued_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_move_issue_seq.sv
// Self-checking bench for move_issue_seq: vector table of single-MOVE programs
// plus hand-written loop, stall, overflow and reset sequences.
module tb_move_issue_seq;

  localparam logic [16:0] W_HALT = 17'h18000;
  localparam logic [16:0] W_LOOP = 17'h10000;
  localparam logic [16:0] W_NOP  = 17'h00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_pc = '0;
  logic [15:0] iterations = '0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [16:0] imem_rdata = '0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [4:0]  op_data1, op_data2;
  logic        op_data1_pointer, op_data2_pointer;
  logic [2:0]  op_cond_sel;
  logic        busy, done, error;
`ifdef MOVE_ISSUE_STATS_EN
  logic [15:0] issued_count;
`endif

  move_issue_seq dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_pc          (base_pc),
    .iterations       (iterations),
    .imem_en          (imem_en),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_data1         (op_data1),
    .op_data2         (op_data2),
    .op_data1_pointer (op_data1_pointer),
    .op_data2_pointer (op_data2_pointer),
    .op_cond_sel      (op_cond_sel),
    .busy             (busy),
    .done             (done),
    .error            (error)
`ifdef MOVE_ISSUE_STATS_EN
    ,
    .issued_count     (issued_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] d1;
    logic [4:0] d2;
    logic       p1;
    logic       p2;
    logic [2:0] cond;
  } move_t;

  typedef struct {
    logic [16:0] word;
    move_t       exp;
  } vec_t;

  logic [16:0] mem [256];
  move_t       exp_q[$];
  int          fetch_log[$];
  int          exp_fetch[$];
  int checks = 0, errors = 0;
  int hs_cnt = 0, done_cnt = 0, cycle = 0, last_hs = 0, hs_gap = 0;
  int valid_run = 0, hs_valid_len = 0;
  logic  held = 1'b0;
  move_t held_fields = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous instruction memory: data valid the cycle after imem_en.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // Monitor sampling on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    move_t cur;
    cur = {op_data1, op_data2, op_data1_pointer, op_data2_pointer, op_cond_sel};
    if (imem_en) fetch_log.push_back(int'(imem_addr));
    if (done) done_cnt++;
    if (op_valid && held) check("hold_stable", cur, held_fields);
    valid_run = op_valid ? valid_run + 1 : 0;
    if (op_valid && op_ready) begin
      if (exp_q.size() == 0) check("unexpected_issue", 1, 0);
      else check("issue_fields", cur, exp_q.pop_front());
      hs_cnt++;
      hs_gap       = cycle - last_hs;
      last_hs      = cycle;
      hs_valid_len = valid_run;
    end
    held        = op_valid && !op_ready;
    held_fields = cur;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = W_HALT;
  endtask

  task automatic check_fetches();
    check("fetch_count", fetch_log.size(), exp_fetch.size());
    for (int i = 0; i < fetch_log.size() && i < exp_fetch.size(); i++)
      check("fetch_addr", fetch_log[i], exp_fetch[i]);
  endtask

  task automatic run_prog(input logic [7:0] bp, input logic [15:0] it,
                          input logic exp_err, input int exp_hs);
    int n;
    fetch_log.delete();
    hs_cnt   = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    base_pc = bp; iterations = it; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("error_at_start", error, 0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("done_pulses", done_cnt, 1);
    check("error_flag", error, exp_err);
    check("handshakes", hs_cnt, exp_hs);
    check("scoreboard_empty", exp_q.size(), 0);
    check_fetches();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{17'h08067, '{5'd3,  5'd7,  1'b0, 1'b0, 3'd0}};
    vecs[1] = '{17'h0D849, '{5'd2,  5'd9,  1'b1, 1'b0, 3'd5}};
    vecs[2] = '{17'h0FFFF, '{5'd31, 5'd31, 1'b1, 1'b1, 3'd7}};
    vecs[3] = '{17'h0A601, '{5'd16, 5'd1,  1'b0, 1'b1, 3'd2}};
    vecs[4] = '{17'h08000, '{5'd0,  5'd0,  1'b0, 1'b0, 3'd0}};
    clear_mem();

    #12;
    check("rst_op_valid", op_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_imem_en", imem_en, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_fields", {op_data1, op_data2, op_data1_pointer, op_data2_pointer, op_cond_sel}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single MOVE + HALT programs from the vector table.
    for (int v = 0; v < 5; v++) begin
      clear_mem();
      mem[8'h20] = vecs[v].word;
      mem[8'h21] = W_HALT;
      exp_q.push_back(vecs[v].exp);
      exp_fetch.delete();
      exp_fetch.push_back(8'h20);
      exp_fetch.push_back(8'h21);
      run_prog(8'h20, 16'd1, 1'b0, 1);
    end

    // Basic program at 0x10 with a 5+ cycle stall and a start while busy.
    clear_mem();
    mem[8'h10] = 17'h08067;
    mem[8'h11] = W_HALT;
    exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    exp_fetch.push_back(8'h10);
    exp_fetch.push_back(8'h11);
    op_ready = 1'b0;
    fork
      begin
        int n = 0;
        while (!op_valid && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; base_pc = 8'h00;
        @(posedge clk); #1;
        start = 1'b0; base_pc = 8'h10;
        op_ready = 1'b1;
      end
    join_none
    run_prog(8'h10, 16'd1, 1'b0, 1);
    check("stall_valid_len_ge6", hs_valid_len >= 6, 1);

    // Counted loop: MOVE, LOOP, HALT.
    clear_mem();
    mem[8'h00] = 17'h08067;
    mem[8'h01] = W_LOOP;
    mem[8'h02] = W_HALT;
    for (int k = 0; k < 3; k++) exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    for (int k = 0; k < 3; k++) begin exp_fetch.push_back(0); exp_fetch.push_back(1); end
    exp_fetch.push_back(2);
    run_prog(8'h00, 16'd3, 1'b0, 3);
`ifdef MOVE_ISSUE_STATS_EN
    check("stats_after_loop", issued_count, 3);
`endif
    exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
    run_prog(8'h00, 16'd0, 1'b0, 1);
`ifdef MOVE_ISSUE_STATS_EN
    check("stats_cleared_on_start", issued_count, 1);
`endif

    // NOPs skipped, one pointer MOVE issued.
    clear_mem();
    mem[8'h40] = W_NOP;
    mem[8'h41] = W_NOP;
    mem[8'h42] = 17'h0D849;
    mem[8'h43] = W_HALT;
    exp_q.push_back(vecs[1].exp);
    exp_fetch.delete();
    for (int k = 8'h40; k <= 8'h43; k++) exp_fetch.push_back(k);
    run_prog(8'h40, 16'd1, 1'b0, 1);

    // Back-to-back MOVEs with op_ready high: 3-cycle issue interval.
    clear_mem();
    mem[8'h60] = vecs[2].word;
    mem[8'h61] = vecs[3].word;
    mem[8'h62] = W_HALT;
    exp_q.push_back(vecs[2].exp);
    exp_q.push_back(vecs[3].exp);
    exp_fetch.delete();
    for (int k = 8'h60; k <= 8'h62; k++) exp_fetch.push_back(k);
    run_prog(8'h60, 16'd1, 1'b0, 2);
    check("issue_interval", hs_gap, 3);

    // PC overflow at 0xFF: error, done, no fetch of 0x00; next start clears error.
    clear_mem();
    mem[8'hFF] = 17'h08067;
    mem[8'h00] = 17'h0D849;
    exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    exp_fetch.push_back(8'hFF);
    run_prog(8'hFF, 16'd1, 1'b1, 1);
    mem[8'h10] = 17'h08067;
    mem[8'h11] = W_HALT;
    exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    exp_fetch.push_back(8'h10);
    exp_fetch.push_back(8'h11);
    run_prog(8'h10, 16'd1, 1'b0, 1);

    // Reset asserted during ISSUE.
    clear_mem();
    mem[8'h30] = 17'h08067;
    mem[8'h31] = W_HALT;
    exp_q.push_back(vecs[0].exp);
    op_ready = 1'b0;
    @(posedge clk); #1;
    base_pc = 8'h30; iterations = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      while (!op_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("valid_timeout", 0, 1);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_mid_op_valid", op_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_imem_en", imem_en, 0);
`ifdef MOVE_ISSUE_STATS_EN
    check("rst_mid_stats", issued_count, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    op_ready = 1'b1;
    exp_q.push_back(vecs[0].exp);
    exp_fetch.delete();
    exp_fetch.push_back(8'h30);
    exp_fetch.push_back(8'h31);
    run_prog(8'h30, 16'd1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_issue_seq.md
Name: move_issue_seq

Overview:
- Upstream neighbour of the move execute stage.
- Fetches packed move-program words from a synchronous instruction memory and decodes them into move argument fields: data1, data2, data1_pointer, data2_pointer, conditional flag select.
- Issues each decoded move to the execute stage over a valid/ready handshake.
- Supports a counted loop back to the program base and a halt opcode. Reports busy, done and error.

Parameters:
ADDR_W, 5, width of an exe_env u32 word index (data1/data2 fields)
COND_W, 3, width of conditional flag select field
PC_W, 8, instruction memory address width
INSTR_W, 2+COND_W+2+2*ADDR_W, instruction word width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin program at base_pc
base_pc  in  PC_W  program start address; also the loop target
iterations  in  16  loop count; 0 treated as 1
imem_en  out  1  instruction memory read enable
imem_addr  out  PC_W  instruction memory read address
imem_rdata  in  INSTR_W  read data, valid the cycle after imem_en
op_valid  out  1  decoded move available
op_ready  in  1  execute stage accepts move
op_data1  out  ADDR_W  first operand address or pointer slot
op_data2  out  ADDR_W  second operand address or pointer slot
op_data1_pointer  out  1  data1 is indirect
op_data2_pointer  out  1  data2 is indirect
op_cond_sel  out  COND_W  conditional flag select
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at program end
error  out  1  sticky until next accepted start; PC overflow

Behaviour:
- Reset values (asynchronous, active-high): state IDLE; all outputs 0; pc 0; iteration counter 0. Reset mid-handshake drops op_valid immediately; no partial state survives.
- Instruction word layout, MSB to LSB:
  - opcode[2]
  - cond_sel[COND_W]
  - p1
  - p2
  - addr1[ADDR_W]
  - addr2[ADDR_W]
- Opcodes:
  - 00 NOP
  - 01 MOVE
  - 10 LOOP
  - 11 HALT
- FSM states: IDLE, FETCH, DECODE, ISSUE, FINISH.
- IDLE:
  - start=1 → pc=base_pc, iter=max(iterations,1), error cleared, busy=1, go to FETCH.
  - start while busy is ignored.
- FETCH: imem_en=1, imem_addr=pc for exactly one cycle → DECODE.
- DECODE: sample imem_rdata.
  - MOVE: register fields onto op_* outputs, op_valid=1 → ISSUE.
  - NOP: pc+1 → FETCH; nothing issued.
  - LOOP with iter>1: iter-1, pc=base_pc → FETCH.
  - LOOP with iter==1: pc+1 → FETCH.
  - HALT: → FINISH.
- ISSUE:
  - op_valid and all op_* held stable until op_valid&op_ready.
  - On the handshake cycle: op_valid drops next cycle, pc+1 → FETCH.
- PC increment from all-ones (wrap) → error=1 → FINISH; no wrap fetch occurs.
- FINISH: done=1 for one cycle, busy=0 → IDLE.
- Minimum issue interval: 3 cycles per MOVE with op_ready held high.
- op_ready while op_valid=0 is ignored.

Optional Feature:
- Macro: MOVE_ISSUE_STATS_EN.
- Defined: adds output issued_count [15:0].
  - Cleared on reset and on accepted start.
  - Increments on each MOVE handshake.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package move_issue_pkg:
  - opcode enum (OP_NOP, OP_MOVE, OP_LOOP, OP_HALT).
  - Packed instruction struct matching the layout above.
  - FSM state enum.
- The move argument struct stays in the existing Move package; op_* maps 1:1 onto its data1/data2/data1_pointer/data2_pointer/conditional fields.
- One natural sub-module: move_instr_decode, combinational; instruction word → opcode + move fields.

Test Plan:
- Program at 0x10: MOVE(a1=3,a2=7,p=00,cond=0), HALT; base_pc=0x10, op_ready=1 → one handshake with data1=3 data2=7, done pulse; exactly 2 fetches (0x10, 0x11).
- Same MOVE with op_ready low for 5 cycles → op_valid held 5+ cycles with fields stable; single handshake; no refetch during stall.
- Program: MOVE, LOOP, HALT with iterations=3 → 3 MOVE handshakes, fetch sequence 0,1,0,1,0,1,2; iterations=0 → 1 handshake.
- Program: NOP, NOP, MOVE(p1=1,p2=0,a1=2,a2=9,cond=5), HALT → only one issue, op_data1_pointer=1, op_cond_sel=5.
- base_pc=0xFF with MOVE at 0xFF, no HALT → MOVE issued, then error=1, done pulse, no fetch of 0x00; next start clears error.
- reset asserted during ISSUE → op_valid, busy low same cycle; start after release runs program from base_pc; with MOVE_ISSUE_STATS_EN, issued_count is 0 after reset.
